// File: rtl/usb_host_xact_if.sv
// Bundle of request, encoder and decoder signals around the host transaction initiator.
// The slave modport is the initiator's view; master is the sequencer/PHY side.
interface usb_host_xact_if;
  logic       xfer_start_i;
  logic [1:0] xfer_type_i;
  logic [6:0] xfer_addr_i;
  logic [3:0] xfer_endp_i;
  logic       xfer_dtog_i;
  logic       xfer_zlp_i;
  logic       xfer_busy_o;
  logic       xfer_done_o;
  logic [1:0] xfer_result_o;
  logic       tok_send_o;
  logic [1:0] tok_type_o;
  logic [6:0] tok_addr_o;
  logic [3:0] tok_endp_o;
  logic       tok_sent_i;
  logic       usb_send_o;
  logic [1:0] usb_type_o;
  logic       usb_busy_i;
  logic       usb_sent_i;
  logic       usb_tvalid_o;
  logic       usb_tlast_o;
  logic [7:0] usb_tdata_o;
  logic       usb_tready_i;
  logic       s_tvalid_i;
  logic       s_tlast_i;
  logic [7:0] s_tdata_i;
  logic       s_tready_o;
  logic       hsk_recv_i;
  logic [1:0] hsk_type_i;
  logic       usb_recv_i;
  logic [1:0] usb_type_i;
  logic       usb_tvalid_i;
  logic       usb_tlast_i;
  logic [7:0] usb_tdata_i;
  logic       usb_tready_o;
  logic       m_tvalid_o;
  logic       m_tlast_o;
  logic [7:0] m_tdata_o;
  logic       m_tready_i;
  logic       hsk_send_o;
  logic [1:0] hsk_type_o;
  logic       hsk_sent_i;

  modport slave (
    input  xfer_start_i, xfer_type_i, xfer_addr_i, xfer_endp_i, xfer_dtog_i, xfer_zlp_i,
    output xfer_busy_o, xfer_done_o, xfer_result_o,
    output tok_send_o, tok_type_o, tok_addr_o, tok_endp_o,
    input  tok_sent_i,
    output usb_send_o, usb_type_o,
    input  usb_busy_i, usb_sent_i,
    output usb_tvalid_o, usb_tlast_o, usb_tdata_o,
    input  usb_tready_i,
    input  s_tvalid_i, s_tlast_i, s_tdata_i,
    output s_tready_o,
    input  hsk_recv_i, hsk_type_i, usb_recv_i, usb_type_i,
    input  usb_tvalid_i, usb_tlast_i, usb_tdata_i,
    output usb_tready_o,
    output m_tvalid_o, m_tlast_o, m_tdata_o,
    input  m_tready_i,
    output hsk_send_o, hsk_type_o,
    input  hsk_sent_i
  );

  modport master (
    output xfer_start_i, xfer_type_i, xfer_addr_i, xfer_endp_i, xfer_dtog_i, xfer_zlp_i,
    input  xfer_busy_o, xfer_done_o, xfer_result_o,
    input  tok_send_o, tok_type_o, tok_addr_o, tok_endp_o,
    output tok_sent_i,
    input  usb_send_o, usb_type_o,
    output usb_busy_i, usb_sent_i,
    input  usb_tvalid_o, usb_tlast_o, usb_tdata_o,
    output usb_tready_i,
    output s_tvalid_i, s_tlast_i, s_tdata_i,
    input  s_tready_o,
    output hsk_recv_i, hsk_type_i, usb_recv_i, usb_type_i,
    output usb_tvalid_i, usb_tlast_i, usb_tdata_i,
    input  usb_tready_o,
    input  m_tvalid_o, m_tlast_o, m_tdata_o,
    output m_tready_i,
    input  hsk_send_o, hsk_type_o,
    output hsk_sent_i
  );
endinterface

// File: rtl/usb_host_xact.sv
// Host-side USB transaction initiator: token, optional DATAx out or in, handshake,
// and a single result code per transaction.
module usb_host_xact #(
  parameter int TIMEOUT = 100,
  parameter int TBITS   = 8
) (
  input logic            clock,
  input logic            reset_n,
  usb_host_xact_if.slave bus
);

  localparam logic [TBITS-1:0] TLIM = TBITS'(TIMEOUT - 1);
  localparam logic [1:0] TYPE_SOF   = 2'b01;
  localparam logic [1:0] TYPE_IN    = 2'b10;
  localparam logic [1:0] TYPE_SETUP = 2'b11;
  localparam logic [1:0] RES_ACK    = 2'b00;
  localparam logic [1:0] RES_ERR    = 2'b01;
  localparam logic [1:0] HSK_NYET   = 2'b01;

  typedef enum logic [6:0] {
    S_IDLE      = 7'b0000001,
    S_TOKEN     = 7'b0000010,
    S_DATA_TX   = 7'b0000100,
    S_WAIT_HSK  = 7'b0001000,
    S_WAIT_DATA = 7'b0010000,
    S_SEND_ACK  = 7'b0100000,
    S_DONE      = 7'b1000000
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       endp_q, endp_d;
  logic             dtog_q, dtog_d;
  logic             zlp_q, zlp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       result_q, result_d;
  logic [1:0]       pend_q, pend_d;
  logic             tok_send_q, tok_send_d;
  logic             usb_send_q, usb_send_d;
  logic             hsk_send_q, hsk_send_d;
  logic [TBITS-1:0] timer_q, timer_d;
  logic             go_done;
  logic [1:0]       done_res;
  logic             tx_pass;
  logic             rx_pass;

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    addr_d     = addr_q;
    endp_d     = endp_q;
    dtog_d     = dtog_q;
    zlp_d      = zlp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    pend_d     = pend_q;
    tok_send_d = tok_send_q;
    usb_send_d = usb_send_q;
    hsk_send_d = hsk_send_q;
    timer_d    = timer_q;
    go_done    = 1'b0;
    done_res   = RES_ACK;

    case (state_q)
      S_IDLE: begin
        if (bus.xfer_start_i) begin
          type_d     = bus.xfer_type_i;
          addr_d     = bus.xfer_addr_i;
          endp_d     = bus.xfer_endp_i;
          dtog_d     = bus.xfer_dtog_i;
          zlp_d      = bus.xfer_zlp_i;
          busy_d     = 1'b1;
          tok_send_d = 1'b1;
          state_d    = S_TOKEN;
        end
      end
      S_TOKEN: begin
        if (bus.tok_sent_i) begin
          tok_send_d = 1'b0;
          timer_d    = '0;
          if (type_q == TYPE_SOF) begin
            go_done  = 1'b1;
            done_res = RES_ACK;
          end else if (type_q == TYPE_IN) begin
            state_d = S_WAIT_DATA;
          end else begin
            state_d    = S_DATA_TX;
            usb_send_d = 1'b1;
          end
        end
      end
      S_DATA_TX: begin
        if (bus.usb_busy_i) usb_send_d = 1'b0;
        if (bus.usb_sent_i) begin
          usb_send_d = 1'b0;
          timer_d    = '0;
          state_d    = S_WAIT_HSK;
        end
      end
      S_WAIT_HSK: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        // Receive events outrank the timeout on the expiry cycle.
        if (bus.hsk_recv_i) begin
          go_done  = 1'b1;
          done_res = (bus.hsk_type_i == HSK_NYET) ? RES_ACK : bus.hsk_type_i;
        end else if (bus.usb_recv_i || timer_q == TLIM) begin
          go_done  = 1'b1;
          done_res = RES_ERR;
        end
      end
      S_WAIT_DATA: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        if (bus.hsk_recv_i) begin
          go_done  = 1'b1;
          done_res = bus.hsk_type_i[1] ? bus.hsk_type_i : RES_ERR;
        end else if (bus.usb_recv_i && !bus.usb_type_i[0]) begin
          // A toggle mismatch is still acknowledged so the device advances.
          state_d    = S_SEND_ACK;
          hsk_send_d = 1'b1;
          pend_d     = (bus.usb_type_i[1] == dtog_q) ? RES_ACK : RES_ERR;
        end else if (bus.usb_recv_i || timer_q == TLIM) begin
          go_done  = 1'b1;
          done_res = RES_ERR;
        end
      end
      S_SEND_ACK: begin
        if (bus.hsk_sent_i) begin
          hsk_send_d = 1'b0;
          go_done    = 1'b1;
          done_res   = pend_q;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (go_done) begin
      state_d  = S_DONE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      result_d = done_res;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      dtog_q     <= 1'b0;
      zlp_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      pend_q     <= '0;
      tok_send_q <= 1'b0;
      usb_send_q <= 1'b0;
      hsk_send_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
      dtog_q     <= dtog_d;
      zlp_q      <= zlp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      pend_q     <= pend_d;
      tok_send_q <= tok_send_d;
      usb_send_q <= usb_send_d;
      hsk_send_q <= hsk_send_d;
      timer_q    <= timer_d;
    end
  end

  assign tx_pass = (state_q == S_DATA_TX) && !zlp_q;
  assign rx_pass = (state_q == S_WAIT_DATA);

  assign bus.xfer_busy_o   = busy_q;
  assign bus.xfer_done_o   = done_q;
  assign bus.xfer_result_o = result_q;
  assign bus.tok_send_o    = tok_send_q;
  assign bus.tok_type_o    = type_q;
  assign bus.tok_addr_o    = addr_q;
  assign bus.tok_endp_o    = endp_q;
  assign bus.usb_send_o    = usb_send_q;
  assign bus.usb_type_o    = (type_q == TYPE_SETUP) ? 2'b00 : {dtog_q, 1'b0};
  assign bus.usb_tvalid_o  = tx_pass && bus.s_tvalid_i;
  assign bus.usb_tlast_o   = tx_pass && bus.s_tlast_i;
  assign bus.usb_tdata_o   = bus.s_tdata_i;
  assign bus.s_tready_o    = tx_pass && bus.usb_tready_i;
  assign bus.m_tvalid_o    = rx_pass && bus.usb_tvalid_i;
  assign bus.m_tlast_o     = rx_pass && bus.usb_tlast_i;
  assign bus.m_tdata_o     = bus.usb_tdata_i;
  assign bus.usb_tready_o  = rx_pass ? bus.m_tready_i : 1'b1;
  assign bus.hsk_send_o    = hsk_send_q;
  assign bus.hsk_type_o    = 2'b00;

endmodule
